// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_arbiter
// Purpose  : Two-master round-robin arbiter and sequencer for the I/O bus.
//            Master 0 is the CPU data port and master 1 is the UART loader.
//            The granted request is latched, its address is decoded into a
//            one-hot device select, and the device signals are held stable
//            until the device reports ready. A watchdog ends accesses that
//            never complete, and decode misses are answered immediately with
//            an error.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            m_req[1:0]        - per-master request, held until that ack
//            m{0,1}_addr/wdata - byte address and write data per master
//            m{0,1}_we/funct3  - write enable and size/sign code per master
//            m_ack[1:0]        - one-cycle completion pulse per master
//            m_err, m_rdata    - error flag and read data, valid with m_ack
//            cs[3:0]           - one-hot device select (ACCESS only)
//            dev_addr/wdata/funct3/we - latched request toward the device
//            dev_rdata, dev_ready     - device response
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [2:0]  m0_funct3,
  input  logic [2:0]  m1_funct3,
  output logic [1:0]  m_ack,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic [3:0]  cs,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [2:0]  dev_funct3,
  output logic        dev_we,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ready
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  logic [1:0]  state_q,  state_d;
  logic        last_q,   last_d;
  logic        idx_q,    idx_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        we_q,     we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [1:0]  ack_q,    ack_d;
  logic        err_q,    err_d;
  logic [31:0] rdata_q,  rdata_d;

  logic        w_gnt;
  logic [31:0] w_sel_addr;
  logic        w_sel_hit;
  logic        w_timeout;

  // With both masters requesting, the one not served last wins; a lone
  // requester always wins.
  assign w_gnt      = (m_req == 2'b11) ? ~last_q : m_req[1];
  assign w_sel_addr = w_gnt ? m1_addr : m0_addr;
  // Devices occupy regions 0x0..0x3 of addr[31:28]; everything else misses.
  assign w_sel_hit  = (w_sel_addr[31:30] == 2'b00);
  assign w_timeout  = (cnt_q == c_timeout);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_idle;
      last_q   <= 1'b1;
      idx_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle: begin
        if (m_req != 2'b00) begin
          state_d = w_sel_hit ? c_access : c_resp;
        end
      end
      c_access: begin
        if (dev_ready || w_timeout) begin
          state_d = c_resp;
        end
      end
      c_resp:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Request latching, watchdog and response registers. The response
  // registers default to zero so they carry data only during RESP.
  always_comb begin
    last_d   = last_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    ack_d    = 2'b00;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      c_idle: begin
        if (m_req != 2'b00) begin
          last_d   = w_gnt;
          idx_d    = w_gnt;
          addr_d   = w_sel_addr;
          wdata_d  = w_gnt ? m1_wdata  : m0_wdata;
          we_d     = w_gnt ? m1_we     : m0_we;
          funct3_d = w_gnt ? m1_funct3 : m0_funct3;
          cnt_d    = '0;
          if (!w_sel_hit) begin
            ack_d   = {w_gnt, ~w_gnt};
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end
        end
      end
      c_access: begin
        // Ready takes priority over a watchdog expiry in the same cycle.
        if (dev_ready) begin
          ack_d   = {idx_q, ~idx_q};
          rdata_d = we_q ? 32'd0 : dev_rdata;
        end else if (w_timeout) begin
          ack_d   = {idx_q, ~idx_q};
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Output logic: device strobes exist only during ACCESS.
  always_comb begin
    cs     = 4'b0000;
    dev_we = 1'b0;
    if (state_q == c_access) begin
      cs     = 4'b0001 << addr_q[29:28];
      dev_we = we_q;
    end
  end

  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign dev_funct3 = funct3_q;
  assign m_ack      = ack_q;
  assign m_err      = err_q;
  assign m_rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_arbiter
// Purpose  : Self-checking bench for io_bus_arbiter. A transaction-level
//            model predicts grant order, select pattern, ACCESS length,
//            ack latency, error flag and returned data for every access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [2:0]  m0_funct3, m1_funct3;
  logic [1:0]  m_ack;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [3:0]  cs;
  logic [31:0] dev_addr, dev_wdata;
  logic [2:0]  dev_funct3;
  logic        dev_we;
  logic [31:0] dev_rdata;
  logic        dev_ready;

  io_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst), .m_req(m_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_funct3(m0_funct3), .m1_funct3(m1_funct3),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .cs(cs), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_funct3(dev_funct3), .dev_we(dev_we),
    .dev_rdata(dev_rdata), .dev_ready(dev_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-master pending transaction as the model sees it.
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rd    [2];
  logic        t_we    [2];
  logic [2:0]  t_f3    [2];
  int          t_lat   [2];   // ACCESS cycle index where ready rises; > TO never
  int          remaining [2]; // extra back-to-back transactions, req held high
  int          model_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_fields();
    m0_addr = t_addr[0];  m1_addr = t_addr[1];
    m0_wdata = t_wdata[0]; m1_wdata = t_wdata[1];
    m0_we = t_we[0];      m1_we = t_we[1];
    m0_funct3 = t_f3[0];  m1_funct3 = t_f3[1];
  endtask

  task automatic set_txn(input int m, input logic [31:0] a, input logic [31:0] w,
                         input logic we, input logic [2:0] f3, input int lat,
                         input logic [31:0] rd);
    t_addr[m] = a; t_wdata[m] = w; t_we[m] = we; t_f3[m] = f3;
    t_lat[m] = lat; t_rd[m] = rd;
    apply_fields();
  endtask

  task automatic rand_txn(input int m);
    logic [3:0] nib;
    nib = 4'($urandom_range(0, 7));
    set_txn(m, {nib, 28'($urandom)}, $urandom, 1'($urandom), 3'($urandom),
            $urandom_range(0, TO + 2), $urandom);
  endtask

  // Serve one access by master s, starting with the DUT in IDLE and s's
  // request visible; ends one cycle after the ack, with the DUT back in IDLE.
  task automatic serve(input int s);
    logic        hit;
    logic [31:0] exp_cs, exp_rd;
    logic        exp_err;
    int          exp_ncs, ncs;
    bit          done;
    hit     = (t_addr[s][31:28] < 4'd4);
    exp_cs  = hit ? (32'd1 << t_addr[s][31:28]) : 32'd0;
    exp_err = !hit || (t_lat[s] > TO);
    exp_ncs = !hit ? 0 : ((t_lat[s] > TO) ? TO + 1 : t_lat[s] + 1);
    exp_rd  = exp_err ? ERRD : (t_we[s] ? 32'd0 : t_rd[s]);
    dev_rdata = t_rd[s];
    ncs  = 0;
    done = 0;
    for (int cyc = 0; cyc < TO + 8 && !done; cyc++) begin
      @(posedge clk); #1;
      if (m_ack != 2'b00) begin
        check_eq("ack_master", 32'(m_ack), (s == 0) ? 32'd1 : 32'd2);
        check_eq("ack_err", 32'(m_err), 32'(exp_err));
        check_eq("ack_rdata", m_rdata, exp_rd);
        check_eq("access_cycles", ncs, exp_ncs);
        check_eq("ack_latency", cyc, exp_ncs);
        check_eq("cs_in_resp", 32'({cs, dev_we}), 32'd0);
        done = 1;
        dev_ready = 1'($urandom);   // must be ignored outside ACCESS
        if (remaining[s] > 0) begin
          remaining[s]--;
          rand_txn(s);
        end else begin
          m_req[s] = 1'b0;
        end
      end else if (cs != 4'b0000) begin
        check_eq("cs", 32'(cs), exp_cs);
        check_eq("dev_addr", dev_addr, t_addr[s]);
        check_eq("dev_wdata", dev_wdata, t_wdata[s]);
        check_eq("dev_funct3", 32'(dev_funct3), 32'(t_f3[s]));
        check_eq("dev_we", 32'(dev_we), 32'(t_we[s]));
        dev_ready = (ncs == t_lat[s]);
        ncs++;
      end else begin
        dev_ready = 1'($urandom);
      end
    end
    if (!done) check_eq("ack_wait_expired", 32'(m_ack), (s == 0) ? 32'd1 : 32'd2);
    @(posedge clk); #1;
    check_eq("idle_strobes", 32'({m_ack, m_err, cs, dev_we}), 32'd0);
    check_eq("idle_rdata", m_rdata, 32'd0);
    dev_ready = 1'($urandom);
  endtask

  // Round-robin reference: the requester other than the last grant wins.
  task automatic run_round(input logic [1:0] mask);
    int s;
    int guard;
    guard = 0;
    m_req = mask;
    while (m_req != 2'b00 && guard < 20) begin
      if (m_req == 2'b11) s = (model_last == 0) ? 1 : 0;
      else                s = m_req[1] ? 1 : 0;
      model_last = s;
      serve(s);
      guard++;
    end
  endtask

  initial begin
    rst = 1'b1; m_req = 2'b00; dev_ready = 1'b0; dev_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      t_addr[m] = '0; t_wdata[m] = '0; t_rd[m] = '0; t_we[m] = 1'b0;
      t_f3[m] = '0; t_lat[m] = 0; remaining[m] = 0;
    end
    apply_fields();
    model_last = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_strobes", 32'({m_ack, m_err, cs, dev_we}), 32'd0);
    check_eq("reset_rdata", m_rdata, 32'd0);
    check_eq("reset_dev_addr", dev_addr, 32'd0);
    check_eq("reset_dev_wdata", dev_wdata, 32'd0);
    check_eq("reset_dev_funct3", 32'(dev_funct3), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention from reset: four transactions alternating 0,1,0,1.
    set_txn(0, 32'h0000_0010, 32'h1111_0000, 1'b0, 3'b010, 1, 32'h0000_1234);
    set_txn(1, 32'h1000_0020, 32'h2222_0000, 1'b1, 3'b001, 0, 32'h0000_5678);
    remaining[0] = 1; remaining[1] = 1;
    run_round(2'b11);

    // Single read, ready in the first ACCESS cycle.
    set_txn(0, 32'h1000_0004, 32'h0, 1'b0, 3'b010, 0, 32'h0000_A5A5);
    run_round(2'b01);

    // Decode miss write from master 1.
    set_txn(1, 32'h7000_0000, 32'h0000_0055, 1'b1, 3'b000, 0, 32'h0);
    run_round(2'b10);

    // Watchdog expiry, then ready in the last permissible cycle.
    set_txn(0, 32'h0000_0100, 32'h0, 1'b0, 3'b010, TO + 1, 32'h0BAD_0BAD);
    run_round(2'b01);
    set_txn(0, 32'h0000_0104, 32'h0, 1'b0, 3'b010, TO, 32'h0600_D000);
    run_round(2'b01);

    // Write path to the UART.
    set_txn(0, 32'h3000_0000, 32'h0000_0041, 1'b1, 3'b000, 2, 32'hFFFF_FFFF);
    run_round(2'b01);

    // Reset during ACCESS to the seven-segment display.
    set_txn(0, 32'h2000_0010, 32'h0000_00AA, 1'b1, 3'b000, TO + 1, 32'h0);
    m_req = 2'b01;
    for (int c = 0; c < 4 && cs != 4'b0100; c++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_reset_cs", 32'(cs), 32'h4);
    rst = 1'b1; m_req = 2'b00;
    @(posedge clk); #1;
    check_eq("midrst_strobes", 32'({m_ack, m_err, cs, dev_we}), 32'd0);
    check_eq("midrst_rdata", m_rdata, 32'd0);
    check_eq("midrst_dev_addr", dev_addr, 32'd0);
    check_eq("midrst_dev_wdata", dev_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_no_ack", 32'(m_ack), 32'd0);
    model_last = 1;
    rand_txn(0); rand_txn(1);
    run_round(2'b11);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        if (mask[m]) begin
          rand_txn(m);
          remaining[m] = $urandom_range(0, 2);
        end
      end
      run_round(mask);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
